// File: rtl/apb_top.sv
// APB2 demo subsystem: request-driven master FSM plus register-file slave.
// Define APB_SLVERR_EN to flag out-of-range addresses with pslverr/slverr.
module apb_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              newd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] ain,
  input  logic [DATA_W-1:0] din,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
`ifdef APB_SLVERR_EN
  input  logic              pslverr,
  output logic              slverr,
`endif
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] dout
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e            state_q, state_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] dout_q, dout_d;
`ifdef APB_SLVERR_EN
  logic              slverr_q, slverr_d;
`endif

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    dout_d   = dout_q;
`ifdef APB_SLVERR_EN
    slverr_d = slverr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (newd) begin
          state_d  = SETUP;
          pwrite_d = wr;
          paddr_d  = ain;
          pwdata_d = din;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          state_d = IDLE;
          if (!pwrite_q) dout_d = prdata;
`ifdef APB_SLVERR_EN
          slverr_d = pslverr;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      dout_q   <= '0;
`ifdef APB_SLVERR_EN
      slverr_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      dout_q   <= dout_d;
`ifdef APB_SLVERR_EN
      slverr_q <= slverr_d;
`endif
    end
  end

  assign psel    = (state_q != IDLE);
  assign penable = (state_q == ACCESS);
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign dout    = dout_q;
`ifdef APB_SLVERR_EN
  assign slverr  = slverr_q;
`endif

endmodule

module apb_slave #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic              s_wait,
`ifdef APB_SLVERR_EN
  output logic              pslverr,
`endif
  output logic              pready,
  output logic [DATA_W-1:0] prdata
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              access;
  logic              acc_ok;

  assign idx    = paddr[IDX_W-1:0];
  assign access = psel & penable;
  assign pready = access & ~s_wait;

`ifdef APB_SLVERR_EN
  logic [31:0] addr_w;
  assign addr_w  = 32'(paddr);
  assign acc_ok  = (addr_w < 32'(MEM_DEPTH));
  assign pslverr = pready & ~acc_ok;
`else
  // Upper address bits alias onto the register file.
  logic unused_addr;
  assign unused_addr = ^paddr[ADDR_W-1:IDX_W];
  assign acc_ok      = 1'b1;
`endif

  assign prdata = (access & acc_ok) ? mem_q[idx] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (pready & pwrite & acc_ok) begin
      mem_q[idx] <= pwdata;
    end
  end

endmodule

module apb_top #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              newd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] ain,
  input  logic [DATA_W-1:0] din,
  input  logic              s_wait,
  output logic [DATA_W-1:0] dout
`ifdef APB_SLVERR_EN
  ,output logic             slverr
`endif
);

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
`ifdef APB_SLVERR_EN
  logic              pslverr;
`endif

  apb_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) m1 (
    .clk     (clk),
    .rstn    (rstn),
    .newd    (newd),
    .wr      (wr),
    .ain     (ain),
    .din     (din),
    .pready  (pready),
    .prdata  (prdata),
`ifdef APB_SLVERR_EN
    .pslverr (pslverr),
    .slverr  (slverr),
`endif
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .dout    (dout)
  );

  apb_slave #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) s1 (
    .clk     (clk),
    .rstn    (rstn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .s_wait  (s_wait),
`ifdef APB_SLVERR_EN
    .pslverr (pslverr),
`endif
    .pready  (pready),
    .prdata  (prdata)
  );

endmodule

// File: tb/tb_apb_top.sv
// Randomized bench for apb_top with a transaction-level reference model.
// Build with APB_SLVERR_EN to also exercise the error response path.
module tb_apb_top;

  logic       clk    = 1'b0;
  logic       rstn   = 1'b0;
  logic       newd   = 1'b0;
  logic       wr     = 1'b0;
  logic [3:0] ain    = '0;
  logic [7:0] din    = '0;
  logic       s_wait = 1'b0;
  logic [7:0] dout;
`ifdef APB_SLVERR_EN
  logic       slverr;
`endif

  apb_top dut (
    .clk    (clk),
    .rstn   (rstn),
    .newd   (newd),
    .wr     (wr),
    .ain    (ain),
    .din    (din),
    .s_wait (s_wait),
    .dout   (dout)
`ifdef APB_SLVERR_EN
    ,.slverr (slverr)
`endif
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b1;

  logic [7:0] mdl_mem [8];
  logic [7:0] exp_dout;
  logic       exp_slverr;
  logic       exp_psel;
  logic       exp_pen;
  logic       exp_rdy;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic bit is_err(input int a);
    bit e;
    e = (a >= 8);
`ifndef APB_SLVERR_EN
    e = 1'b0;
`endif
    return e;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 8; i++) mdl_mem[i] = '0;
    exp_dout   = '0;
    exp_slverr = 1'b0;
    exp_psel   = 1'b0;
    exp_pen    = 1'b0;
    exp_rdy    = 1'b0;
  endtask

  // Per-cycle comparison, sampled shortly after the falling edge.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("psel", 32'(dut.m1.psel), 32'(exp_psel));
      chk("penable", 32'(dut.m1.penable), 32'(exp_pen));
      chk("pready", 32'(dut.m1.pready), 32'(exp_rdy));
      chk("dout", 32'(dout), 32'(exp_dout));
`ifdef APB_SLVERR_EN
      chk("slverr", 32'(slverr), 32'(exp_slverr));
`endif
    end
  end

  // Called at a falling edge with the master idle; returns likewise.
  task automatic xfer(input bit w, input int a, input int d,
                      input int waits, input bit keep);
    int  idx;
    bit  err;
    newd     = 1'b1;
    wr       = w;
    ain      = 4'(a);
    din      = 8'(d);
    s_wait   = 1'($urandom);
    exp_psel = 1'b0;
    exp_pen  = 1'b0;
    exp_rdy  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exp_psel = 1'b1;
    newd     = keep;
    wr       = 1'($urandom);
    ain      = 4'($urandom);
    din      = 8'($urandom);
    s_wait   = 1'($urandom);
    @(posedge clk);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      s_wait   = (i < waits);
      exp_psel = 1'b1;
      exp_pen  = 1'b1;
      exp_rdy  = (i == waits);
      @(posedge clk);
    end
    idx = a % 8;
    err = is_err(a);
    if (w && !err) mdl_mem[idx] = 8'(d);
    if (!w) exp_dout = err ? 8'd0 : mdl_mem[idx];
    exp_slverr = err;
    @(negedge clk);
    exp_psel = 1'b0;
    exp_pen  = 1'b0;
    exp_rdy  = 1'b0;
    s_wait   = 1'($urandom);
  endtask

  initial begin
    mdl_reset();
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b1;

    for (int a = 0; a < 8; a++) xfer(1'b0, a, 0, 0, 1'b0);

    xfer(1'b1, 2, 150, 0, 1'b0);
    chk("mem2_lit", 32'(dut.s1.mem_q[2]), 32'd150);

    xfer(1'b1, 3, 200, 3, 1'b0);
    chk("mem3_lit", 32'(dut.s1.mem_q[3]), 32'd200);

    xfer(1'b0, 2, 0, 2, 1'b0);
    chk("dout_rd2_lit", 32'(dout), 32'd150);
    xfer(1'b1, 5, 77, 1, 1'b0);
    chk("dout_hold_lit", 32'(dout), 32'd150);

    for (int i = 0; i < 5; i++)
      xfer(1'b1, i, int'($urandom_range(255)), int'($urandom_range(3)), 1'b1);
    for (int i = 0; i < 5; i++)
      xfer(1'b0, i, 0, int'($urandom_range(3)), i < 4);
    xfer(1'b0, 6, 0, 1, 1'b0);
    chk("unwritten6_lit", 32'(dout), 32'd0);
    xfer(1'b0, 7, 0, 0, 1'b0);

    repeat (40)
      xfer(1'($urandom), int'($urandom_range(15)), int'($urandom_range(255)),
           int'($urandom_range(3)), 1'($urandom));
    newd = 1'b0;

`ifdef APB_SLVERR_EN
    xfer(1'b1, 0, 55, 0, 1'b0);
    xfer(1'b0, 0, 0, 0, 1'b0);
    xfer(1'b0, 9, 0, 0, 1'b0);
    chk("slverr_lit", 32'(slverr), 32'd1);
    chk("err_dout_lit", 32'(dout), 32'd0);
`endif

    xfer(1'b1, 1, 42, 0, 1'b0);
    xfer(1'b0, 1, 0, 0, 1'b0);
    chk("dout_pre_abort_lit", 32'(dout), 32'd42);

    // Abort a write during its wait-extended ACCESS phase.
    newd = 1'b1;
    wr   = 1'b1;
    ain  = 4'd1;
    din  = 8'd99;
    @(posedge clk);
    @(negedge clk);
    exp_psel = 1'b1;
    newd     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s_wait  = 1'b1;
    exp_pen = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    mdl_reset();
    @(negedge clk);
    @(negedge clk);
    rstn   = 1'b1;
    s_wait = 1'b0;
    chk("abort_mem1_lit", 32'(dut.s1.mem_q[1]), 32'd0);
    chk("abort_dout_lit", 32'(dout), 32'd0);
    xfer(1'b0, 1, 0, 1, 1'b0);
    xfer(1'b0, 2, 0, 0, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
